// File: rtl/prach_tdm_pattern_gen.sv
// PRACH TDM stimulus generator: emits cfg_len sample periods of NUM_CHN TDM
// beats on an Avalon-ST style bus, placing a mode-dependent pattern on the
// selected channel slot of the masked antenna lanes.
module prach_tdm_pattern_gen #(
  parameter int unsigned NUM_ANT = 8,
  parameter int unsigned NUM_CHN = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned CHN_W   = 8
) (
  input  logic                  clk_jesd,
  input  logic                  rst_jesd_n,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [15:0]           cfg_len,
  input  logic [NUM_ANT-1:0]    cfg_ant_mask,
  input  logic [CHN_W-1:0]      cfg_chn_sel,
  input  logic [DW-1:0]         cfg_amp,
  input  logic [15:0]           cfg_sync_dly,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_ANT*DW-1:0] avst_source_data,
  output logic                  avst_source_valid,
  output logic [CHN_W-1:0]      avst_source_channel,
  output logic                  sync_out
);

  localparam int unsigned HW = DW / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_ZERO, M_IMPULSE, M_CONST, M_RAMP} mode_t;

  state_t               r_state, w_state_nxt;
  mode_t                r_mode, w_mode;
  logic [15:0]          r_len;
  logic [NUM_ANT-1:0]   r_mask, w_mask;
  logic [CHN_W-1:0]     r_sel, w_sel;
  logic [DW-1:0]        r_amp, w_amp;
  logic [15:0]          r_sync_dly, w_sync_dly;

  logic [CHN_W-1:0]     r_chn, w_chn_nxt;
  logic [15:0]          r_smp, w_smp_nxt;
  logic [31:0]          r_beat, w_beat_nxt;

  logic                 r_busy, r_done, r_valid, r_sync;
  logic [NUM_ANT*DW-1:0] r_data, w_data;
  logic                 w_valid_nxt, w_sync;
  logic [DW-1:0]        w_lane;
  logic                 w_accept, w_wrap, w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_wrap   = (r_chn == CHN_W'(NUM_CHN - 1));
  assign w_last   = w_wrap && (r_smp == r_len - 16'd1);

  // On the accepting cycle the latched config is not yet loaded, so beat 0 is
  // built from the live cfg inputs; afterwards only the latched copy is used.
  assign w_mode     = w_accept ? mode_t'(cfg_mode) : r_mode;
  assign w_mask     = w_accept ? cfg_ant_mask      : r_mask;
  assign w_sel      = w_accept ? cfg_chn_sel       : r_sel;
  assign w_amp      = w_accept ? cfg_amp           : r_amp;
  assign w_sync_dly = w_accept ? cfg_sync_dly      : r_sync_dly;

  // Next state and next beat position (counters idle at zero outside RUN)
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_chn_nxt   = '0;
    w_smp_nxt   = '0;
    w_beat_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_len == 16'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_valid_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_valid_nxt = 1'b1;
          w_beat_nxt  = r_beat + 32'd1;
          if (w_wrap) begin
            w_smp_nxt = r_smp + 16'd1;
          end else begin
            w_chn_nxt = r_chn + CHN_W'(1);
            w_smp_nxt = r_smp;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane pattern and sync flag for the beat about to be registered
  always_comb begin
    unique case (w_mode)
      M_ZERO:    w_lane = '0;
      M_IMPULSE: w_lane = (w_smp_nxt == 16'd0) ? w_amp : '0;
      M_CONST:   w_lane = w_amp;
      M_RAMP:    w_lane = {HW'(w_smp_nxt), HW'(w_smp_nxt)};
      default:   w_lane = '0;
    endcase
    w_data = '0;
    w_sync = 1'b0;
    if (w_valid_nxt) begin
      w_sync = (w_beat_nxt == {16'd0, w_sync_dly});
      for (int unsigned a = 0; a < NUM_ANT; a++) begin
        if (w_mask[a] && (w_chn_nxt == w_sel)) begin
          w_data[NUM_ANT*DW-1-DW*a -: DW] = w_lane;
        end
      end
    end
  end

  // State, config latch, counters and registered outputs
  always_ff @(posedge clk_jesd) begin
    if (!rst_jesd_n) begin
      r_state    <= S_IDLE;
      r_mode     <= M_ZERO;
      r_len      <= '0;
      r_mask     <= '0;
      r_sel      <= '0;
      r_amp      <= '0;
      r_sync_dly <= '0;
      r_chn      <= '0;
      r_smp      <= '0;
      r_beat     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_sync     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mode     <= mode_t'(cfg_mode);
        r_len      <= cfg_len;
        r_mask     <= cfg_ant_mask;
        r_sel      <= cfg_chn_sel;
        r_amp      <= cfg_amp;
        r_sync_dly <= cfg_sync_dly;
      end
      r_chn   <= w_chn_nxt;
      r_smp   <= w_smp_nxt;
      r_beat  <= w_beat_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
      r_valid <= w_valid_nxt;
      r_sync  <= w_sync;
      r_data  <= w_data;
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign avst_source_valid   = r_valid;
  assign avst_source_channel = r_chn;
  assign avst_source_data    = r_data;
  assign sync_out            = r_sync;

endmodule

// File: tb/tb_prach_tdm_pattern_gen.sv
// Directed bench for prach_tdm_pattern_gen: table of burst configurations with
// hand-computed results, plus reset-abort and alternate-parameter sequences.
module tb_prach_tdm_pattern_gen;

  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   cfg_mode;
  logic [15:0]  cfg_len;
  logic [7:0]   cfg_ant_mask;
  logic [7:0]   cfg_chn_sel;
  logic [31:0]  cfg_amp;
  logic [15:0]  cfg_sync_dly;
  logic         busy, done, valid, sync_out;
  logic [255:0] data;
  logic [7:0]   chn;

  logic         start2;
  logic [1:0]   cfg_mode2;
  logic [15:0]  cfg_len2;
  logic [3:0]   cfg_ant_mask2;
  logic [7:0]   cfg_chn_sel2;
  logic [23:0]  cfg_amp2;
  logic [15:0]  cfg_sync_dly2;
  logic         busy2, done2, valid2, sync_out2;
  logic [95:0]  data2;
  logic [7:0]   chn2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prach_tdm_pattern_gen #(.NUM_ANT(8), .NUM_CHN(4), .DW(32), .CHN_W(8)) dut (
    .clk_jesd(clk), .rst_jesd_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_ant_mask(cfg_ant_mask), .cfg_chn_sel(cfg_chn_sel),
    .cfg_amp(cfg_amp), .cfg_sync_dly(cfg_sync_dly), .busy(busy), .done(done),
    .avst_source_data(data), .avst_source_valid(valid),
    .avst_source_channel(chn), .sync_out(sync_out)
  );

  prach_tdm_pattern_gen #(.NUM_ANT(4), .NUM_CHN(6), .DW(24), .CHN_W(8)) dut2 (
    .clk_jesd(clk), .rst_jesd_n(rst_n), .start(start2), .cfg_mode(cfg_mode2),
    .cfg_len(cfg_len2), .cfg_ant_mask(cfg_ant_mask2), .cfg_chn_sel(cfg_chn_sel2),
    .cfg_amp(cfg_amp2), .cfg_sync_dly(cfg_sync_dly2), .busy(busy2), .done(done2),
    .avst_source_data(data2), .avst_source_valid(valid2),
    .avst_source_channel(chn2), .sync_out(sync_out2)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [15:0]  len;
    logic [7:0]   mask;
    logic [7:0]   sel;
    logic [31:0]  amp;
    logic [15:0]  sdly;
    int           mid_start;   // beat index at which a stray start is pulsed, -1 none
    int           exp_beats;
    int           exp_sync;    // beat index of sync_out, -1 none
    int           exp_nz;      // number of beats with non-zero data
    int           probe;       // beat index whose data is compared, -1 none
    logic [255:0] probe_data;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int sync_at, nz, nval;
    bit fin;
    @(negedge clk);
    cfg_mode = v.mode; cfg_len = v.len; cfg_ant_mask = v.mask;
    cfg_chn_sel = v.sel; cfg_amp = v.amp; cfg_sync_dly = v.sdly;
    start = 1'b1;
    sync_at = -1; nz = 0; nval = 0; fin = 1'b0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        chk($sformatf("v%0d busy_in_run@%0d", idx, c), busy, 1'b1);
        chk($sformatf("v%0d channel@%0d", idx, c), chn, c % NC);
        if (data != '0) nz++;
        if (c == v.probe) chk($sformatf("v%0d probe_data@%0d", idx, c), data, v.probe_data);
        if (sync_out) begin
          if (sync_at >= 0) chk($sformatf("v%0d sync_once", idx), c, sync_at);
          sync_at = c;
        end
      end else begin
        chk($sformatf("v%0d done_at_end", idx), done, 1'b1);
        chk($sformatf("v%0d end_cycle", idx), c, v.exp_beats);
        chk($sformatf("v%0d busy_at_done", idx), busy, 1'b0);
        chk($sformatf("v%0d sync_at_done", idx), sync_out, 1'b0);
        chk($sformatf("v%0d data_at_done", idx), data, 256'h0);
        chk($sformatf("v%0d chan_at_done", idx), chn, 8'h0);
        fin = 1'b1;
      end
      if (c == 0) begin
        // later cfg changes must not disturb the running burst
        cfg_mode = ~cfg_mode; cfg_len = cfg_len + 16'd7; cfg_ant_mask = ~cfg_ant_mask;
        cfg_chn_sel = cfg_chn_sel + 8'd1; cfg_amp = ~cfg_amp; cfg_sync_dly = cfg_sync_dly + 16'd1;
      end
      start = (c == v.mid_start);
    end
    start = 1'b0;
    chk($sformatf("v%0d timeout", idx), fin, 1'b1);
    chk($sformatf("v%0d beats", idx), nval, v.exp_beats);
    chk($sformatf("v%0d sync_beat", idx), sync_at, v.exp_sync);
    chk($sformatf("v%0d nonzero_beats", idx), nz, v.exp_nz);
    @(negedge clk);
    chk($sformatf("v%0d done_width", idx), done, 1'b0);
    chk($sformatf("v%0d idle_busy", idx), busy, 1'b0);
    chk($sformatf("v%0d idle_valid", idx), valid, 1'b0);
  endtask

  initial begin
    int nval;
    bit fin;

    //          mode  len     mask   sel   amp            sdly      mid  beats sync nz probe data
    tbl[0] = '{2'd1, 16'd1000, 8'h01, 8'd0, 32'd16384,     16'hFFFF, -1, 4000, -1, 1, 0,  {32'h00004000, 224'h0}};
    tbl[1] = '{2'd3, 16'd5,    8'hFF, 8'd2, 32'h0,         16'd0,     6,   20,  0, 4, 14, {8{32'h00030003}}};
    tbl[2] = '{2'd2, 16'd3,    8'h81, 8'd1, 32'hDEADBEEF,  16'd5,    -1,   12,  5, 3, 5,  {32'hDEADBEEF, 192'h0, 32'hDEADBEEF}};
    tbl[3] = '{2'd2, 16'd3,    8'h81, 8'd1, 32'hDEADBEEF,  16'd12,   -1,   12, -1, 3, 9,  {32'hDEADBEEF, 192'h0, 32'hDEADBEEF}};
    tbl[4] = '{2'd2, 16'd0,    8'hFF, 8'd0, 32'hFFFFFFFF,  16'd0,    -1,    0, -1, 0, -1, 256'h0};
    tbl[5] = '{2'd2, 16'd2,    8'hFF, 8'd4, 32'hFFFFFFFF,  16'd7,    -1,    8,  7, 0, 5,  256'h0};
    tbl[6] = '{2'd0, 16'd2,    8'hFF, 8'd0, 32'hFFFFFFFF,  16'd3,    -1,    8,  3, 0, 4,  256'h0};
    tbl[7] = '{2'd1, 16'd2,    8'h10, 8'd3, 32'h12345678,  16'd11,   -1,    8, -1, 1, 3,  {128'h0, 32'h12345678, 96'h0}};
    tbl[8] = '{2'd3, 16'd3,    8'h40, 8'd0, 32'h0,         16'd11,   -1,   12, 11, 2, 8,  {192'h0, 32'h00020002, 32'h0}};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    cfg_mode = '0; cfg_len = '0; cfg_ant_mask = '0; cfg_chn_sel = '0; cfg_amp = '0; cfg_sync_dly = '0;
    cfg_mode2 = '0; cfg_len2 = '0; cfg_ant_mask2 = '0; cfg_chn_sel2 = '0; cfg_amp2 = '0; cfg_sync_dly2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset valid", valid, 1'b0);
    chk("reset sync", sync_out, 1'b0);
    chk("reset channel", chn, 8'h0);
    chk("reset data", data, 256'h0);
    chk("reset valid2", valid2, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // Reset in the middle of a len=10 burst, then immediate restart
    @(negedge clk);
    cfg_mode = 2'd2; cfg_len = 16'd10; cfg_ant_mask = 8'hFF; cfg_chn_sel = 8'd0;
    cfg_amp = 32'h1; cfg_sync_dly = 16'hFFFF;
    start = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("abort valid@%0d", c), valid, 1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort valid", valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort data", data, 256'h0);
    rst_n = 1'b1;
    cfg_len = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart valid", valid, 1'b1);
    chk("restart busy", busy, 1'b1);
    chk("restart done", done, 1'b0);
    chk("restart channel", chn, 8'h0);
    nval = 1; fin = 1'b0;
    for (int c = 1; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (valid) nval++;
      else if (done) fin = 1'b1;
    end
    chk("restart finished", fin, 1'b1);
    chk("restart beats", nval, 8);
    run_vec(9, tbl[2]);

    // Alternate geometry: 4 antennas x 6 channels x 24 bits
    @(negedge clk);
    cfg_mode2 = 2'd2; cfg_len2 = 16'd2; cfg_ant_mask2 = 4'b1000; cfg_chn_sel2 = 8'd5;
    cfg_amp2 = 24'h123456; cfg_sync_dly2 = 16'hFFFF;
    start2 = 1'b1;
    nval = 0; fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (valid2) begin
        nval++;
        chk($sformatf("p2 channel@%0d", c), chn2, c % 6);
        chk($sformatf("p2 data@%0d", c), data2, (c % 6 == 5) ? 96'h123456 : 96'h0);
        chk($sformatf("p2 sync@%0d", c), sync_out2, 1'b0);
      end else begin
        chk("p2 done_at_end", done2, 1'b1);
        chk("p2 end_cycle", c, 12);
        fin = 1'b1;
      end
    end
    chk("p2 finished", fin, 1'b1);
    chk("p2 beats", nval, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
